eth_std_main_system_button_event_master: RTL

//  Avalon-MM initiator that services an edge-capturing button PIO: programs its irq_mask

---
 rtl/eth_std_main_system_button_event_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/eth_std_main_system_button_event_master.sv
`default_nettype none
// ============================================================================
// Module   : eth_std_main_system_button_event_master
// Brief    : Avalon-MM initiator servicing an edge-capture button PIO and
//            forwarding captured edges as a valid/ready event stream.
// Revision : 1.0
// ============================================================================
module eth_std_main_system_button_event_master #(
   parameter int unsigned           WIDTH          = 3,
   parameter logic [WIDTH-1:0]      IRQ_MASK       = '1,
   parameter int unsigned           HOLDOFF_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [1:0]        address,
   output logic              chipselect,
   output logic              write_n,
   output logic [31:0]       writedata,
   input  logic [31:0]       readdata,
   input  logic              irq,
   output logic              evt_valid,
   output logic [WIDTH-1:0]  evt_data,
   input  logic              evt_ready,
   output logic [15:0]       evt_count
);

   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_IDLE = 3'd1,
      S_RD   = 3'd2,
      S_CAP  = 3'd3,
      S_EMIT = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_address, w_address;
   logic             r_cs, w_cs;
   logic             r_wn, w_wn;
   logic [31:0]      r_wdata, w_wdata;
   logic             r_evt_valid, w_evt_valid;
   logic [WIDTH-1:0] r_evt_data, w_evt_data;
   logic [15:0]      r_evt_count, w_evt_count;
   logic [HW-1:0]    r_hold, w_hold;
   logic [31:0]      w_unused_rd;
   logic [WIDTH-1:0] w_sample;

   assign w_unused_rd = readdata;
   assign w_sample    = w_unused_rd[WIDTH-1:0] & IRQ_MASK;

   // Bus outputs are computed for the state being entered, so each access
   // appears on the registered outputs for exactly the cycle after the decision.
   always_comb begin
      w_state_nxt = r_state;
      w_address   = 2'd0;
      w_cs        = 1'b0;
      w_wn        = 1'b1;
      w_wdata     = 32'd0;
      w_evt_valid = r_evt_valid;
      w_evt_data  = r_evt_data;
      w_evt_count = r_evt_count;
      w_hold      = r_hold;
      case (r_state)
         S_INIT: begin
            w_cs        = 1'b1;
            w_wn        = 1'b0;
            w_address   = 2'd2;
            w_wdata     = 32'(IRQ_MASK);
            w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (irq) begin
               w_cs        = 1'b1;
               w_address   = 2'd3;
               w_state_nxt = S_RD;
            end
         end
         S_RD: begin
            w_cs        = 1'b1;
            w_wn        = 1'b0;
            w_address   = 2'd3;
            w_state_nxt = S_CAP;
         end
         S_CAP: begin
            w_evt_data = w_sample;
            if (w_sample != '0) begin
               w_evt_valid = 1'b1;
               w_state_nxt = S_EMIT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_EMIT: begin
            if (r_evt_valid && evt_ready) begin
               w_evt_valid = 1'b0;
               w_evt_count = r_evt_count + 16'd1;
               if (HOLDOFF_CYCLES > 0) begin
                  w_hold      = HW'(HOLDOFF_CYCLES - 1);
                  w_state_nxt = S_HOLD;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (r_hold == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_hold = r_hold - HW'(1);
            end
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_INIT;
         r_address   <= 2'd0;
         r_cs        <= 1'b0;
         r_wn        <= 1'b1;
         r_wdata     <= 32'd0;
         r_evt_valid <= 1'b0;
         r_evt_data  <= '0;
         r_evt_count <= 16'd0;
         r_hold      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_address   <= w_address;
         r_cs        <= w_cs;
         r_wn        <= w_wn;
         r_wdata     <= w_wdata;
         r_evt_valid <= w_evt_valid;
         r_evt_data  <= w_evt_data;
         r_evt_count <= w_evt_count;
         r_hold      <= w_hold;
      end
   end

   assign address    = r_address;
   assign chipselect = r_cs;
   assign write_n    = r_wn;
   assign writedata  = r_wdata;
   assign evt_valid  = r_evt_valid;
   assign evt_data   = r_evt_data;
   assign evt_count  = r_evt_count;

endmodule
`default_nettype wire
